regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Write-side front end for the 32x64 integer register file.
- Merges two writeback sources into the file's single write port:
  - the in-order ALU pipeline: single-cycle results, highest priority;
  - the long-latency load/store unit (LSU): results buffered in a small FIFO.
- Drives the register file's rd / write_data / reg_write through registers.
- Exports a pending-write scoreboard to the hazard unit and resolves write-after-write (WAW) ordering between the two sources.

Parameters:
- DATA_W, 64, writeback data width
- ADDR_W, 5, register index width
- DEPTH, 4, LSU result FIFO entries (power of 2, >=2)
- MAX_WAIT, 3, cycles a FIFO head may be bypassed by ALU writes before it forces a grant

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU writeback request this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle; pipeline holds WB while low
- lsu_valid  in  1  LSU result available
- lsu_rd  in  ADDR_W  LSU destination register
- lsu_data  in  DATA_W  LSU result
- lsu_ready  out  1  FIFO can accept; push on lsu_valid & lsu_ready
- rd  out  ADDR_W  register file write index
- write_data  out  DATA_W  register file write data
- reg_write  out  1  register file write enable
- busy_mask  out  32  bit i = an uncancelled queued write to x_i is pending
- pending_count  out  $clog2(DEPTH)+1  FIFO occupancy, cancelled entries included

Behaviour:
- Reset (reset==0 at clk edge):
  - rd=0, write_data=0, reg_write=0;
  - FIFO emptied; all cancel flags cleared; head age=0; busy_mask=0; pending_count=0.
  - Applies mid-operation; queued results are discarded.
- Reset-low ready outputs: lsu_ready=0 and alu_ready=1 in any cycle where reset==0.
- Output timing: rd, write_data and reg_write are registered. The write for a grant made in cycle N appears in cycle N+1 for exactly one cycle.
- x0 filter:
  - requests with rd==0 never produce reg_write=1;
  - an ALU request with rd==0 is accepted (alu_ready unaffected);
  - an LSU push with rd==0 is accepted but not enqueued.
- lsu_ready = (pending_count < DEPTH). It is based on current-cycle occupancy only: a full FIFO popping this cycle still shows lsu_ready=0.
- head_starved = FIFO non-empty & head age >= MAX_WAIT.
- alu_ready = ~head_starved.
- Grant priority each cycle:
  1. If alu_valid & alu_ready & alu_rd!=0: grant ALU.
  2. Else if the FIFO is non-empty: pop the head. Issue a write only if the head is not cancelled; a cancelled head pops silently with reg_write=0 next cycle.
  3. Else: reg_write=0 next cycle.
- Head age:
  - increments each cycle the FIFO is non-empty and the head is not popped;
  - resets to 0 on every pop;
  - saturates at MAX_WAIT.
- WAW cancel:
  - When an ALU write to register X is granted, every queued entry with rd==X gets its cancel flag set in the same cycle. The ALU write is younger and must win.
  - An LSU entry pushed in that same cycle with rd==X is NOT cancelled, because it is younger than the ALU write.
- Simultaneous push and pop: both occur; pending_count is unchanged.
- Push while empty and no ALU grant: the entry is enqueued and can pop no earlier than the next cycle. There is no same-cycle bypass.
- busy_mask: combinational OR over valid, uncancelled entries. It reflects state after the last clock edge.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by pending_count.

Test Plan:
- Reset: hold reset=0 for 2 cycles with lsu_valid=1 -> lsu_ready=0; reg_write=0, busy_mask=0, pending_count=0 throughout.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0x1234 in cycle N -> cycle N+1: reg_write=1, rd=5, write_data=0x1234; cycle N+2: reg_write=0.
- LSU path and x0 drop:
  - push lsu_rd=7/data=0xAA, then lsu_rd=0/data=0xBB, with no ALU traffic;
  - required: busy_mask bit7 set then cleared; exactly one write, rd=7 data=0xAA; pending_count never exceeds 1.
- Full and starvation:
  - fill the FIFO with 4 pushes while alu_valid=1 every cycle to distinct rd!=0;
  - required: lsu_ready=0 at pending_count=4; after 3 bypassed cycles alu_ready=0 and the head pops next; alu_ready returns to 1 the cycle after the pop.
- WAW cancel:
  - queue LSU write rd=9/data=0x11, then ALU grant rd=9/data=0x22;
  - required: busy_mask bit9 clears; register file sees only the 0x22 write to x9; the cancelled pop produces reg_write=0.
- Mid-operation reset: reset=0 with 3 entries queued -> next cycle pending_count=0, busy_mask=0; no queued write is ever issued.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Write-port front end for the 32x64 register file: merges single-cycle ALU
// results with a small LSU result FIFO, tracks pending writes and resolves WAW.
module regfile_writeback_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [ADDR_W-1:0]        lsu_rd,
  input  logic [DATA_W-1:0]        lsu_data,
  output logic                     lsu_ready,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        write_data,
  output logic                     reg_write,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic [ADDR_W-1:0] r_qRd   [DEPTH];
  logic [DATA_W-1:0] r_qData [DEPTH];
  logic [DEPTH-1:0]  r_qValid;
  logic [DEPTH-1:0]  r_qCancel;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [AGE_W-1:0]  r_headAge;

  logic w_empty;
  logic w_headStarved;
  logic w_aluGrant;
  logic w_pop;
  logic w_popWrite;
  logic w_push;
  logic [31:0] w_busy;

  always_comb begin
    w_empty       = (r_count == '0);
    w_headStarved = !w_empty && (r_headAge >= AGE_W'(MAX_WAIT));
    alu_ready     = !reset || !w_headStarved;
    lsu_ready     = reset && (r_count < CNT_W'(DEPTH));
    w_aluGrant    = reset && alu_valid && alu_ready && (alu_rd != '0);
    w_pop         = reset && !w_aluGrant && !w_empty;
    w_popWrite    = w_pop && !r_qCancel[r_rdPtr];
    // x0 pushes are handshaken but never stored
    w_push        = reset && lsu_valid && lsu_ready && (lsu_rd != '0);
    pending_count = r_count;
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_qValid[i] && !r_qCancel[i]) w_busy[r_qRd[i]] = 1'b1;
    end
    busy_mask = w_busy;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qRd[r_wrPtr]   <= lsu_rd;
      r_qData[r_wrPtr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd         <= '0;
      write_data <= '0;
      reg_write  <= 1'b0;
      r_qValid   <= '0;
      r_qCancel  <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_headAge  <= '0;
    end else begin
      reg_write <= w_aluGrant || w_popWrite;
      if (w_aluGrant) begin
        rd         <= alu_rd;
        write_data <= alu_data;
      end else if (w_popWrite) begin
        rd         <= r_qRd[r_rdPtr];
        write_data <= r_qData[r_rdPtr];
      end
      // Older queued writes to the ALU's target must not overwrite it later
      for (int i = 0; i < DEPTH; i++) begin
        if (w_aluGrant && r_qValid[i] && (r_qRd[i] == alu_rd)) r_qCancel[i] <= 1'b1;
      end
      if (w_pop) begin
        r_qValid[r_rdPtr] <= 1'b0;
        r_rdPtr           <= r_rdPtr + PTR_W'(1);
      end
      if (w_push) begin
        r_qValid[r_wrPtr]  <= 1'b1;
        r_qCancel[r_wrPtr] <= 1'b0;
        r_wrPtr            <= r_wrPtr + PTR_W'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_pop)                                        r_headAge <= '0;
      else if (!w_empty && !w_headStarved)              r_headAge <= r_headAge + AGE_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized and directed bench for regfile_writeback_arbiter, checked every
// cycle against a queue-based model of the writeback rules.
module tb_regfile_writeback_arbiter;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic [31:0]       busy_mask;
  logic [$clog2(DEPTH):0] pending_count;

  regfile_writeback_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .busy_mask(busy_mask), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    bit                cancel;
  } entry_t;

  entry_t            mq[$];
  int                mAge = 0;
  bit                mWrite = 0;
  logic [ADDR_W-1:0] mRd = '0;
  logic [DATA_W-1:0] mData = '0;
  bit                modelInit = 0;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelBusy();
    logic [31:0] m = '0;
    foreach (mq[i]) if (!mq[i].cancel) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // Compare every DUT output against the model state for the current cycle
  task automatic checkOutput();
    bit starved;
    if (!modelInit) return;
    starved = (mq.size() > 0) && (mAge >= MAX_WAIT);
    check("alu_ready", 64'(alu_ready), 64'(!reset || !starved));
    check("lsu_ready", 64'(lsu_ready), 64'(reset && (mq.size() < DEPTH)));
    check("pending_count", 64'(pending_count), 64'(mq.size()));
    check("busy_mask", 64'(busy_mask), 64'(modelBusy()));
    check("reg_write", 64'(reg_write), 64'(mWrite));
    if (mWrite) begin
      check("rd", 64'(rd), 64'(mRd));
      check("write_data", write_data, mData);
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs
  task automatic modelStep();
    bit starved, grantAlu, wasNonEmpty, popped, pushNow;
    entry_t h;
    if (!reset) begin
      mq.delete();
      mAge = 0;
      mWrite = 0;
      modelInit = 1;
      return;
    end
    wasNonEmpty = mq.size() > 0;
    starved  = wasNonEmpty && (mAge >= MAX_WAIT);
    grantAlu = alu_valid && !starved && (alu_rd != 0);
    pushNow  = lsu_valid && (mq.size() < DEPTH) && (lsu_rd != 0);
    popped = 0;
    mWrite = 0;
    if (grantAlu) begin
      foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].cancel = 1;
      mWrite = 1; mRd = alu_rd; mData = alu_data;
    end else if (wasNonEmpty) begin
      h = mq.pop_front();
      popped = 1;
      if (!h.cancel) begin
        mWrite = 1; mRd = h.rd; mData = h.data;
      end
    end
    if (popped) mAge = 0;
    else if (wasNonEmpty && mAge < MAX_WAIT) mAge++;
    if (pushNow) begin
      h.rd = lsu_rd; h.data = lsu_data; h.cancel = 0;
      mq.push_back(h);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit av, input int ard, input longint adata,
                               input bit lv, input int lrd, input longint ldata);
    @(negedge clk);
    reset     = r;
    alu_valid = av;
    alu_rd    = ADDR_W'(ard);
    alu_data  = DATA_W'(adata);
    lsu_valid = lv;
    lsu_rd    = ADDR_W'(lrd);
    lsu_data  = DATA_W'(ldata);
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    // Reset held with an LSU request present
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 3, 64'h55);
      if (k > 0) begin
        check("rst lsu_ready", 64'(lsu_ready), 64'd0);
        check("rst reg_write", 64'(reg_write), 64'd0);
        check("rst busy_mask", 64'(busy_mask), 64'd0);
        check("rst pending", 64'(pending_count), 64'd0);
      end
    end

    // ALU path
    applyStimulus(1, 1, 5, 64'h1234, 0, 0, 0);
    idle(1);
    check("alu reg_write", 64'(reg_write), 64'd1);
    check("alu rd", 64'(rd), 64'd5);
    check("alu data", write_data, 64'h1234);
    idle(1);
    check("alu reg_write off", 64'(reg_write), 64'd0);

    // LSU path with an x0 push that must be dropped
    applyStimulus(1, 0, 0, 0, 1, 7, 64'hAA);
    applyStimulus(1, 0, 0, 0, 1, 0, 64'hBB);
    check("lsu busy7 set", 64'(busy_mask[7]), 64'd1);
    check("lsu pending 1", 64'(pending_count), 64'd1);
    idle(1);
    check("lsu reg_write", 64'(reg_write), 64'd1);
    check("lsu rd", 64'(rd), 64'd7);
    check("lsu data", write_data, 64'hAA);
    check("lsu busy7 clear", 64'(busy_mask[7]), 64'd0);
    idle(1);
    check("x0 no write", 64'(reg_write), 64'd0);
    idle(1);

    // Fill the FIFO under constant ALU traffic until the head starves
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, k + 1, k + 64'h100, 1, k + 10, k + 64'h200);
    applyStimulus(1, 1, 6, 64'h106, 1, 20, 64'h300);
    check("full lsu_ready", 64'(lsu_ready), 64'd0);
    check("full pending", 64'(pending_count), 64'd4);
    check("starved alu_ready", 64'(alu_ready), 64'd0);
    applyStimulus(1, 1, 6, 64'h106, 0, 0, 0);
    check("unstarved alu_ready", 64'(alu_ready), 64'd1);
    check("head pop rd", 64'(rd), 64'd10);
    check("head pop data", write_data, 64'h200);
    idle(6);

    // WAW: ALU write to x9 cancels the queued LSU write to x9
    applyStimulus(1, 0, 0, 0, 1, 9, 64'h11);
    applyStimulus(1, 1, 9, 64'h22, 0, 0, 0);
    check("waw busy9 set", 64'(busy_mask[9]), 64'd1);
    idle(1);
    check("waw busy9 clear", 64'(busy_mask[9]), 64'd0);
    check("waw alu data", write_data, 64'h22);
    check("waw pending", 64'(pending_count), 64'd1);
    idle(1);
    check("waw cancelled pop", 64'(reg_write), 64'd0);
    check("waw drained", 64'(pending_count), 64'd0);

    // Reset with three queued entries
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, k + 1, 64'h40, 1, k + 20, 64'h50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    check("mid pending 3", 64'(pending_count), 64'd3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    check("mid pending 0", 64'(pending_count), 64'd0);
    check("mid busy 0", 64'(busy_mask), 64'd0);
    idle(3);

    // Randomized traffic with a small register set to provoke WAW hits
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 79) != 0,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 7), {$urandom, $urandom},
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7), {$urandom, $urandom});
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
